spu_local_store: RTL and testbench



---
 rtl/spu_local_store_if.sv | 29 ++
 rtl/spu_local_store.sv | 113 +++++++++++
 tb/tb_spu_local_store.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spu_local_store_if.sv
// Request/response bundle between the odd-pipe LSU / fetch unit and the SPU local store.
// master = requester side, slave = local store side.
interface spu_local_store_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) ();
    logic                  dat_req;
    logic                  dat_we;
    logic [ADDR_W-1:0]     dat_addr;
    logic [LINE_W-1:0]     dat_wdata;
    logic [LINE_W/8-1:0]   dat_be;
    logic                  ld_valid;
    logic [LINE_W-1:0]     ld_data;
    logic                  fetch_req;
    logic [ADDR_W-1:0]     fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_valid;
    logic [LINE_W-1:0]     fetch_data;

    modport master (
        output dat_req, dat_we, dat_addr, dat_wdata, dat_be, fetch_req, fetch_addr,
        input  ld_valid, ld_data, fetch_gnt, fetch_valid, fetch_data
    );

    modport slave (
        input  dat_req, dat_we, dat_addr, dat_wdata, dat_be, fetch_req, fetch_addr,
        output ld_valid, ld_data, fetch_gnt, fetch_valid, fetch_data
    );
endinterface

// File: rtl/spu_local_store.sv
// SPU local store: single-port line array, data port has priority over fetch,
// fixed-latency load and fetch return pipelines. Array contents are never reset.
module spu_local_store #(
    parameter int LS_BYTES = 32768,
    parameter int LINE_W   = 128,
    parameter int LAT      = 6,
    parameter int ADDR_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    spu_local_store_if.slave bus
);
    localparam int BPL   = LINE_W / 8;
    localparam int OFF_W = $clog2(BPL);
    localparam int DEPTH = LS_BYTES / BPL;
    localparam int IDX_W = $clog2(DEPTH);

    // Wrap modulo the store size and drop the in-line byte offset.
    function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] wrapped;
        wrapped  = addr & ADDR_W'(LS_BYTES - 1);
        line_idx = IDX_W'(wrapped >> OFF_W);
    endfunction

    logic [LINE_W-1:0] mem_r [DEPTH];

    logic              ld_vld_r [LAT];
    logic [LINE_W-1:0] ld_dat_r [LAT];
    logic              fe_vld_r [LAT];
    logic [LINE_W-1:0] fe_dat_r [LAT];

    logic [IDX_W-1:0]  dat_idx_s;
    logic [IDX_W-1:0]  fetch_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [LINE_W-1:0] rd_line_s;
    logic              st_issue_s;
    logic              ld_issue_s;
    logic              fetch_gnt_s;

    // Arbitration and single array read port selection.
    always_comb begin
        dat_idx_s   = line_idx(bus.dat_addr);
        fetch_idx_s = line_idx(bus.fetch_addr);
        st_issue_s  = bus.dat_req & bus.dat_we;
        ld_issue_s  = bus.dat_req & ~bus.dat_we;
        fetch_gnt_s = bus.fetch_req & ~bus.dat_req;
        if (bus.dat_req) begin
            rd_idx_s = dat_idx_s;
        end else begin
            rd_idx_s = fetch_idx_s;
        end
        rd_line_s = mem_r[rd_idx_s];
    end

    // Byte-enabled store, applied at the end of the issue cycle.
    always_ff @(posedge clk) begin
        if (st_issue_s) begin
            for (int b = 0; b < BPL; b++) begin
                if (bus.dat_be[b]) begin
                    mem_r[dat_idx_s][8*b +: 8] <= bus.dat_wdata[8*b +: 8];
                end
            end
        end
    end

    // Load return pipeline; data stages only advance with valid so outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                ld_vld_r[i] <= 1'b0;
                ld_dat_r[i] <= {LINE_W{1'b0}};
            end
        end else begin
            ld_vld_r[0] <= ld_issue_s;
            if (ld_issue_s) begin
                ld_dat_r[0] <= rd_line_s;
            end
            for (int i = 1; i < LAT; i++) begin
                ld_vld_r[i] <= ld_vld_r[i-1];
                if (ld_vld_r[i-1]) begin
                    ld_dat_r[i] <= ld_dat_r[i-1];
                end
            end
        end
    end

    // Fetch return pipeline, independent of the load pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                fe_vld_r[i] <= 1'b0;
                fe_dat_r[i] <= {LINE_W{1'b0}};
            end
        end else begin
            fe_vld_r[0] <= fetch_gnt_s;
            if (fetch_gnt_s) begin
                fe_dat_r[0] <= rd_line_s;
            end
            for (int i = 1; i < LAT; i++) begin
                fe_vld_r[i] <= fe_vld_r[i-1];
                if (fe_vld_r[i-1]) begin
                    fe_dat_r[i] <= fe_dat_r[i-1];
                end
            end
        end
    end

    assign bus.fetch_gnt   = fetch_gnt_s;
    assign bus.ld_valid    = ld_vld_r[LAT-1];
    assign bus.ld_data     = ld_dat_r[LAT-1];
    assign bus.fetch_valid = fe_vld_r[LAT-1];
    assign bus.fetch_data  = fe_dat_r[LAT-1];
endmodule

// File: tb/tb_spu_local_store.sv
// Directed self-checking bench for spu_local_store (default 32 KiB, 128-bit lines, LAT=6).
module tb_spu_local_store;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] P1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] PA   = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
    localparam logic [127:0] PG   = 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    localparam logic [127:0] PQ   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    spu_local_store_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    spu_local_store #(
        .LS_BYTES(32768), .LINE_W(128), .LAT(LAT), .ADDR_W(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [127:0] stream_line(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, w, w, w};
    endfunction

    task automatic drive_dat(input logic req, input logic we, input logic [31:0] addr,
                             input logic [127:0] wd, input logic [15:0] be);
        bus.dat_req   = req;
        bus.dat_we    = we;
        bus.dat_addr  = addr;
        bus.dat_wdata = wd;
        bus.dat_be    = be;
    endtask

    task automatic drive_idle();
        drive_dat(1'b0, 1'b0, 32'h0, 128'h0, 16'h0);
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'h0;
    endtask

    task automatic store_line(input logic [31:0] addr, input logic [127:0] wd, input logic [15:0] be);
        @(negedge clk);
        drive_dat(1'b1, 1'b1, addr, wd, be);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_idle();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ld_valid !== 1'b0) begin errors++; $display("FAIL reset_ld_valid got %b exp 0", bus.ld_valid); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %b exp 0", bus.fetch_valid); end
        checks++; if (bus.ld_data !== 128'h0) begin errors++; $display("FAIL reset_ld_data got %h exp 0", bus.ld_data); end
        checks++; if (bus.fetch_data !== 128'h0) begin errors++; $display("FAIL reset_fetch_data got %h exp 0", bus.fetch_data); end
        checks++; if (bus.fetch_gnt !== 1'b0) begin errors++; $display("FAIL reset_fetch_gnt got %b exp 0", bus.fetch_gnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive_dat(1'b1, 1'b1, 32'h40, P1, 16'hFFFF);
        @(negedge clk);
        drive_dat(1'b1, 1'b0, 32'h4C, 128'h0, 16'h0);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ld_valid !== (k == LAT)) begin
                errors++; $display("FAIL store_load_valid k=%0d got %b exp %b", k, bus.ld_valid, (k == LAT));
            end
            if (k == LAT) begin
                checks++;
                if (bus.ld_data !== P1) begin errors++; $display("FAIL store_load_data got %h exp %h", bus.ld_data, P1); end
            end
            if (k == LAT + 2) begin
                checks++;
                if (bus.ld_data !== P1) begin errors++; $display("FAIL ld_data_hold got %h exp %h", bus.ld_data, P1); end
            end
            drive_idle();
        end
    endtask

    task automatic test_byte_enable();
        store_line(32'h80, ONES, 16'hFFFF);
        @(negedge clk);
        drive_dat(1'b1, 1'b1, 32'h80, 128'h0, 16'h00FF);
        @(negedge clk);
        drive_dat(1'b1, 1'b1, 32'h80, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'h0000);
        @(negedge clk);
        drive_dat(1'b1, 1'b0, 32'h80, 128'h0, 16'h0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            drive_idle();
            if (k == LAT) begin
                checks++;
                if (bus.ld_valid !== 1'b1) begin errors++; $display("FAIL be_valid got %b exp 1", bus.ld_valid); end
                checks++;
                if (bus.ld_data !== 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000) begin
                    errors++; $display("FAIL be_data got %h exp %h", bus.ld_data, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
                end
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive_dat(1'b1, 1'b1, 32'h0000_8010, PA, 16'hFFFF);
        @(negedge clk);
        drive_dat(1'b1, 1'b0, 32'h0000_0010, 128'h0, 16'h0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            drive_idle();
            if (k == LAT) begin
                checks++;
                if (bus.ld_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", bus.ld_valid); end
                checks++;
                if (bus.ld_data !== PA) begin errors++; $display("FAIL wrap_data got %h exp %h", bus.ld_data, PA); end
            end
        end
    endtask

    task automatic test_arbitration();
        for (int c = 0; c <= LAT + 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ld_valid !== (c == LAT + 1 || c == LAT + 2)) begin
                errors++; $display("FAIL arb_ld_valid c=%0d got %b", c, bus.ld_valid);
            end
            if (c == LAT + 1 || c == LAT + 2) begin
                checks++;
                if (bus.ld_data !== P1) begin errors++; $display("FAIL arb_ld_data c=%0d got %h exp %h", c, bus.ld_data, P1); end
            end
            checks++;
            if (bus.fetch_valid !== (c == 3 + LAT)) begin
                errors++; $display("FAIL arb_fetch_valid c=%0d got %b", c, bus.fetch_valid);
            end
            if (c == 3 + LAT) begin
                checks++;
                if (bus.fetch_data !== PG) begin errors++; $display("FAIL arb_fetch_data got %h exp %h", bus.fetch_data, PG); end
            end
            if (c == 0) drive_dat(1'b1, 1'b1, 32'h100, PG, 16'hFFFF);
            else if (c <= 2) drive_dat(1'b1, 1'b0, 32'h40, 128'h0, 16'h0);
            else drive_dat(1'b0, 1'b0, 32'h0, 128'h0, 16'h0);
            bus.fetch_req  = (c <= 3);
            bus.fetch_addr = 32'h100;
            #1;
            if (c <= 3) begin
                checks++;
                if (bus.fetch_gnt !== (c == 3)) begin
                    errors++; $display("FAIL arb_fetch_gnt c=%0d got %b exp %b", c, bus.fetch_gnt, (c == 3));
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 20; i++) store_line(32'(i * 16), stream_line(i), 16'hFFFF);
        for (int c = 0; c <= 20 + LAT; c++) begin
            @(negedge clk);
            checks++;
            if (bus.fetch_valid !== (c >= LAT && c < LAT + 20)) begin
                errors++; $display("FAIL stream_valid c=%0d got %b", c, bus.fetch_valid);
            end
            if (c >= LAT && c < LAT + 20) begin
                checks++;
                if (bus.fetch_data !== stream_line(c - LAT)) begin
                    errors++; $display("FAIL stream_data c=%0d got %h exp %h", c, bus.fetch_data, stream_line(c - LAT));
                end
            end
            bus.fetch_req  = (c < 20);
            bus.fetch_addr = 32'(c * 16);
            #1;
            if (c < 20) begin
                checks++;
                if (bus.fetch_gnt !== 1'b1) begin errors++; $display("FAIL stream_gnt c=%0d got %b exp 1", c, bus.fetch_gnt); end
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        store_line(32'h200, PQ, 16'hFFFF);
        for (int c = 0; c <= LAT + 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ld_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid c=%0d got %b exp 0", c, bus.ld_valid); end
            if (c == 4) begin
                checks++;
                if (bus.ld_data !== 128'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", bus.ld_data); end
            end
            if (c <= 2) drive_dat(1'b1, 1'b0, 32'h200, 128'h0, 16'h0);
            else drive_idle();
            if (c == 3) rst_n = 1'b0;
            if (c == 4) rst_n = 1'b1;
        end
        @(negedge clk);
        drive_dat(1'b1, 1'b0, 32'h200, 128'h0, 16'h0);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            drive_idle();
            checks++;
            if (bus.ld_valid !== (k == LAT)) begin
                errors++; $display("FAIL retained_valid k=%0d got %b exp %b", k, bus.ld_valid, (k == LAT));
            end
            if (k == LAT) begin
                checks++;
                if (bus.ld_data !== PQ) begin errors++; $display("FAIL retained_data got %h exp %h", bus.ld_data, PQ); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_wrap();
        test_arbitration();
        test_streaming();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
